// File: rtl/cdc_pkg.sv
// cdc_pkg: types and defaults shared by the stages of the toggle-handshake
// CDC path (trigger-chain source and hs_rx receiver).
//   state_t          receiver FSM state (IDLE, VALID)
//   CDC_W            default data width
//   CDC_SYNC_STAGES  default request synchronizer depth (legal 2..4)
//   CDC_CNT_W        default transfer counter width
package cdc_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      VALID = 1'b1
   } state_t;

   localparam int unsigned CDC_W           = 4;
   localparam int unsigned CDC_SYNC_STAGES = 2;
   localparam int unsigned CDC_CNT_W       = 8;

endpackage

// File: rtl/cdc_hs_rx_if.sv
// cdc_hs_rx_if: handshake bundle between the source domain, the receiver
// and the downstream consumer.
//   IREQ    toggle request from the source domain (asynchronous)
//   IDATA   source data word, held stable across the handshake
//   IREADY  downstream ready
//   ODATA   captured word
//   OVALID  ODATA valid
//   OACK    toggle acknowledge back to the source domain
//   OCNT    completed transfer count (wrapping)
//   OERR    sticky protocol-violation flag
// slave modport is the receiver's view; master is the environment's view.
interface cdc_hs_rx_if
   import cdc_pkg::*;
#(
   parameter int unsigned W     = CDC_W,
   parameter int unsigned CNT_W = CDC_CNT_W
);

   logic             IREQ;
   logic [W-1:0]     IDATA;
   logic             IREADY;
   logic [W-1:0]     ODATA;
   logic             OVALID;
   logic             OACK;
   logic [CNT_W-1:0] OCNT;
   logic             OERR;

   modport slave (
      input  IREQ, IDATA, IREADY,
      output ODATA, OVALID, OACK, OCNT, OERR
   );

   modport master (
      output IREQ, IDATA, IREADY,
      input  ODATA, OVALID, OACK, OCNT, OERR
   );

endinterface

// File: rtl/cdc_hs_rx_sync_chain.sv
// sync_chain: plain flop chain synchronizer, asynchronous reset to 0,
// no logic between stages.
//   CLK  destination clock
//   RST  asynchronous active-high reset
//   D    asynchronous input
//   Q    synchronized output (STAGES edges of latency)
module sync_chain #(
   parameter int unsigned STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic D,
   output logic Q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   generate
      if (STAGES == 1) begin : g_one
         assign sync_d = D;
      end else begin : g_many
         assign sync_d = {sync_q[STAGES-2:0], D};
      end
   endgenerate

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign Q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// cdc_hs_rx: receive side of the toggle-handshake CDC path.
// Synchronizes the source toggle request, captures the source word on a
// detected toggle, presents it on valid/ready and toggles the acknowledge
// back to the source once the word is accepted downstream.
//   CLK  receive-domain clock
//   RST  asynchronous active-high reset
//   bus  cdc_hs_rx_if.slave (IREQ/IDATA/IREADY in, ODATA/OVALID/OACK/OCNT/OERR out)
module cdc_hs_rx
   import cdc_pkg::*;
#(
   parameter int unsigned W           = CDC_W,
   parameter int unsigned SYNC_STAGES = CDC_SYNC_STAGES,
   parameter int unsigned CNT_W       = CDC_CNT_W
) (
   input  logic        CLK,
   input  logic        RST,
   cdc_hs_rx_if.slave  bus
);

   state_t           state_q;
   logic             req_s;
   logic             req_q;
   logic             toggle;
   logic [W-1:0]     odata_q;
   logic             ovalid_q;
   logic             oack_q;
   logic [CNT_W-1:0] ocnt_q;
   logic [CNT_W-1:0] ocnt_d;
   logic             oerr_q;

   // IDATA is deliberately not synchronized: the source holds it stable
   // from before the request toggle until it sees the acknowledge toggle.
   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .CLK (CLK),
      .RST (RST),
      .D   (bus.IREQ),
      .Q   (req_s)
   );

   assign toggle = req_s ^ req_q;

   always_comb begin
      ocnt_d = ocnt_q + 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         odata_q  <= '0;
         ovalid_q <= 1'b0;
         oack_q   <= 1'b0;
         ocnt_q   <= '0;
         oerr_q   <= 1'b0;
      end else begin
         req_q <= req_s;
         case (state_q)
            IDLE: begin
               if (toggle) begin
                  odata_q  <= bus.IDATA;
                  ovalid_q <= 1'b1;
                  state_q  <= VALID;
               end
            end
            VALID: begin
               // A second toggle before our ack is dropped and flagged.
               if (toggle) begin
                  oerr_q <= 1'b1;
               end
               if (ovalid_q && bus.IREADY) begin
                  ovalid_q <= 1'b0;
                  oack_q   <= ~oack_q;
                  ocnt_q   <= ocnt_d;
                  state_q  <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.ODATA  = odata_q;
   assign bus.OVALID = ovalid_q;
   assign bus.OACK   = oack_q;
   assign bus.OCNT   = ocnt_q;
   assign bus.OERR   = oerr_q;

endmodule

// File: tb/tb_cdc_hs_rx.sv
module tb_cdc_hs_rx;
   import cdc_pkg::*;

   logic CLK;
   logic RST;

   int tests;
   int fails;

   logic       exp_ack;
   logic [7:0] exp_cnt;

   cdc_hs_rx_if #(.W(4), .CNT_W(8)) b0 ();
   cdc_hs_rx_if #(.W(4), .CNT_W(2)) b1 ();

   cdc_hs_rx #(.W(4), .SYNC_STAGES(2), .CNT_W(8)) u_dut (
      .CLK (CLK),
      .RST (RST),
      .bus (b0)
   );

   cdc_hs_rx #(.W(4), .SYNC_STAGES(2), .CNT_W(2)) u_wrap (
      .CLK (CLK),
      .RST (RST),
      .bus (b1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Pulse reset away from clock edges; source levels restart at 0 too.
   task automatic do_reset();
      b0.IREQ   = 1'b0;
      b0.IREADY = 1'b0;
      b1.IREQ   = 1'b0;
      b1.IREADY = 1'b0;
      RST = 1'b1;
      #2;
      RST = 1'b0;
      exp_ack = 1'b0;
      exp_cnt = 8'd0;
      tick();
   endtask

   task automatic test_reset_values();
      tests++; if (b0.ODATA !== 4'h0) begin fails++; $display("FAIL rst_odata got=%h exp=0", b0.ODATA); end
      tests++; if (b0.OVALID !== 1'b0) begin fails++; $display("FAIL rst_ovalid got=%b exp=0", b0.OVALID); end
      tests++; if (b0.OACK !== 1'b0) begin fails++; $display("FAIL rst_oack got=%b exp=0", b0.OACK); end
      tests++; if (b0.OCNT !== 8'd0) begin fails++; $display("FAIL rst_ocnt got=%0d exp=0", b0.OCNT); end
      tests++; if (b0.OERR !== 1'b0) begin fails++; $display("FAIL rst_oerr got=%b exp=0", b0.OERR); end
   endtask

   task automatic test_single();
      b0.IREADY = 1'b1;
      b0.IDATA  = 4'h5;
      b0.IREQ   = ~b0.IREQ;
      ticks(2);
      tests++; if (b0.OVALID !== 1'b0) begin fails++; $display("FAIL single_early_valid got=%b exp=0", b0.OVALID); end
      tick();
      tests++; if (b0.OVALID !== 1'b1) begin fails++; $display("FAIL single_valid_e3 got=%b exp=1", b0.OVALID); end
      tests++; if (b0.ODATA !== 4'h5) begin fails++; $display("FAIL single_odata_e3 got=%h exp=5", b0.ODATA); end
      tests++; if (b0.OACK !== exp_ack) begin fails++; $display("FAIL single_ack_e3 got=%b exp=%b", b0.OACK, exp_ack); end
      tick();
      exp_ack = ~exp_ack;
      exp_cnt = exp_cnt + 8'd1;
      tests++; if (b0.OACK !== 1'b1) begin fails++; $display("FAIL single_ack_e4 got=%b exp=1", b0.OACK); end
      tests++; if (b0.OCNT !== 8'd1) begin fails++; $display("FAIL single_cnt_e4 got=%0d exp=1", b0.OCNT); end
      tests++; if (b0.OVALID !== 1'b0) begin fails++; $display("FAIL single_valid_e4 got=%b exp=0", b0.OVALID); end
      b0.IREADY = 1'b0;
   endtask

   task automatic test_reset_mid_valid();
      b0.IREADY = 1'b0;
      b0.IDATA  = 4'hA;
      b0.IREQ   = ~b0.IREQ;
      ticks(3);
      tests++; if (b0.ODATA !== 4'hA || b0.OVALID !== 1'b1) begin fails++; $display("FAIL rstmid_pre got=%h/%b exp=a/1", b0.ODATA, b0.OVALID); end
      RST = 1'b1;
      b0.IREQ = 1'b0;
      #1;
      test_reset_values();
      #1;
      RST = 1'b0;
      exp_ack = 1'b0;
      exp_cnt = 8'd0;
      ticks(5);
      tests++; if (b0.OVALID !== 1'b0) begin fails++; $display("FAIL rstmid_idle got=%b exp=0", b0.OVALID); end
   endtask

   task automatic test_backpressure();
      b0.IREADY = 1'b0;
      b0.IDATA  = 4'hC;
      b0.IREQ   = ~b0.IREQ;
      ticks(3);
      for (int i = 0; i < 10; i++) begin
         tests++; if (b0.OVALID !== 1'b1 || b0.ODATA !== 4'hC) begin fails++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/c", i, b0.OVALID, b0.ODATA); end
         tests++; if (b0.OACK !== exp_ack) begin fails++; $display("FAIL bp_ack[%0d] got=%b exp=%b", i, b0.OACK, exp_ack); end
         tick();
      end
      b0.IREADY = 1'b1;
      tick();
      exp_ack = ~exp_ack;
      exp_cnt = exp_cnt + 8'd1;
      tests++; if (b0.OACK !== exp_ack) begin fails++; $display("FAIL bp_accept_ack got=%b exp=%b", b0.OACK, exp_ack); end
      tests++; if (b0.OVALID !== 1'b0) begin fails++; $display("FAIL bp_accept_valid got=%b exp=0", b0.OVALID); end
      tests++; if (b0.OCNT !== exp_cnt) begin fails++; $display("FAIL bp_cnt got=%0d exp=%0d", b0.OCNT, exp_cnt); end
      b0.IREADY = 1'b0;
   endtask

   task automatic test_source_model();
      logic [3:0] d;
      logic [3:0] got;
      logic       prev_v;
      logic       rdy;
      logic       done;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         d = 4'($urandom_range(0, 15));
         b0.IDATA = d;
         b0.IREQ  = ~b0.IREQ;
         got  = 'x;
         done = 1'b0;
         for (int t = 0; t < 60 && !done; t++) begin
            rdy = 1'($urandom_range(0, 1));
            b0.IREADY = rdy;
            prev_v = b0.OVALID;
            if (prev_v) got = b0.ODATA;
            tick();
            if (b0.OACK !== exp_ack) begin
               done = 1'b1;
               exp_ack = ~exp_ack;
               exp_cnt = exp_cnt + 8'd1;
               tests++; if (!(prev_v && rdy)) begin fails++; $display("FAIL src_ack_cond[%0d] got=valid%b/ready%b exp=1/1", i, prev_v, rdy); end
            end else begin
               tests++; if (prev_v && !b0.OVALID) begin fails++; $display("FAIL src_valid_drop[%0d] got=0 exp=1", i); end
            end
         end
         tests++; if (!done) begin fails++; $display("FAIL src_timeout[%0d] got=no_ack exp=ack", i); end
         tests++; if (got !== d) begin fails++; $display("FAIL src_data[%0d] got=%h exp=%h", i, got, d); end
      end
      b0.IREADY = 1'b0;
      tick();
      tests++; if (b0.OCNT !== 8'd20) begin fails++; $display("FAIL src_cnt got=%0d exp=20", b0.OCNT); end
      tests++; if (b0.OERR !== 1'b0) begin fails++; $display("FAIL src_err got=%b exp=0", b0.OERR); end
   endtask

   task automatic test_violation();
      b0.IREADY = 1'b0;
      b0.IDATA  = 4'h9;
      b0.IREQ   = ~b0.IREQ;
      ticks(3);
      tests++; if (b0.OERR !== 1'b0) begin fails++; $display("FAIL viol_err_pre got=%b exp=0", b0.OERR); end
      b0.IDATA = 4'h3;
      b0.IREQ  = ~b0.IREQ;
      ticks(2);
      b0.IREQ  = ~b0.IREQ;
      ticks(4);
      tests++; if (b0.OERR !== 1'b1) begin fails++; $display("FAIL viol_err got=%b exp=1", b0.OERR); end
      tests++; if (b0.OVALID !== 1'b1 || b0.ODATA !== 4'h9) begin fails++; $display("FAIL viol_hold got=%b/%h exp=1/9", b0.OVALID, b0.ODATA); end
      tests++; if (b0.OCNT !== exp_cnt) begin fails++; $display("FAIL viol_cnt_pre got=%0d exp=%0d", b0.OCNT, exp_cnt); end
      b0.IREADY = 1'b1;
      tick();
      exp_ack = ~exp_ack;
      exp_cnt = exp_cnt + 8'd1;
      tests++; if (b0.OACK !== exp_ack) begin fails++; $display("FAIL viol_ack got=%b exp=%b", b0.OACK, exp_ack); end
      ticks(6);
      tests++; if (b0.OCNT !== exp_cnt) begin fails++; $display("FAIL viol_cnt got=%0d exp=%0d", b0.OCNT, exp_cnt); end
      tests++; if (b0.OVALID !== 1'b0) begin fails++; $display("FAIL viol_no_extra got=%b exp=0", b0.OVALID); end
      tests++; if (b0.OERR !== 1'b1) begin fails++; $display("FAIL viol_sticky got=%b exp=1", b0.OERR); end
      b0.IREADY = 1'b0;
   endtask

   task automatic test_wrap();
      logic [1:0] exp_seq [5];
      exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      b1.IREADY = 1'b1;
      for (int i = 0; i < 5; i++) begin
         b1.IDATA = 4'(i + 1);
         b1.IREQ  = ~b1.IREQ;
         ticks(4);
         tests++; if (b1.OCNT !== exp_seq[i]) begin fails++; $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d", i, b1.OCNT, exp_seq[i]); end
         ticks(1);
      end
      tests++; if (b1.OERR !== 1'b0) begin fails++; $display("FAIL wrap_err got=%b exp=0", b1.OERR); end
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      exp_ack = 1'b0;
      exp_cnt = 8'd0;
      b0.IREQ = 1'b0; b0.IDATA = 4'h0; b0.IREADY = 1'b0;
      b1.IREQ = 1'b0; b1.IDATA = 4'h0; b1.IREADY = 1'b0;
      RST = 1'b1;
      #2;
      test_reset_values();
      #1;
      RST = 1'b0;
      tick();
      test_single();
      test_reset_mid_valid();
      test_backpressure();
      test_source_model();
      test_violation();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/cdc_hs_rx.md
# cdc_hs_rx

Receive-side stage of the toggle-handshake CDC path. Consumes the 4-bit data word produced by the trigger-chain stage in a foreign clock domain, plus a toggle request from that domain. Synchronizes the request into CLK and captures the word. Presents the word on a valid/ready interface, then returns a toggle acknowledge to the source domain.

## Interface
- W, 4: data width; matches the trigger-chain output width.
- SYNC_STAGES, 2: flip-flops in the request synchronizer; legal range 2..4.
- CNT_W, 8: width of the transfer counter.

- CLK  in  1  receive-domain clock; all state on its rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IREQ  in  1  toggle request from the source domain; asynchronous to CLK.
- IDATA  in  W  source-domain data; stable from before the IREQ toggle until OACK toggle returns.
- IREADY  in  1  downstream ready.
- ODATA  out  W  captured word; registered.
- OVALID  out  1  ODATA valid; registered.
- OACK  out  1  toggle acknowledge to the source domain; registered, glitch-free.
- OCNT  out  CNT_W  number of completed transfers; wraps modulo 2^CNT_W.
- OERR  out  1  sticky protocol-violation flag.

## Operation
- IREQ passes through a SYNC_STAGES-deep flop chain giving req_s. Only req_s may be used by logic. IDATA is never synchronized; it is captured only when a toggle is detected, relying on the source hold rule.
- req_q is a register holding the previous req_s. A toggle event is defined as req_s != req_q. req_q <= req_s every cycle.
- States IDLE, VALID; the enum lives in the package.
- IDLE + toggle: ODATA <= IDATA, OVALID <= 1, go to VALID.
- VALID: ODATA and OVALID are held. When OVALID & IREADY: OVALID <= 0, OACK <= ~OACK, OCNT <= OCNT+1, go to IDLE.
- A toggle event while in VALID is a protocol violation: the source toggled again before the ack. Required response:
  - OERR <= 1 and stays 1 until RST.
  - The event is dropped; ODATA and the state are unaffected.
- Toggle in IDLE on the same cycle VALID is left: impossible by construction (state is VALID on that cycle, so the rule above applies).
- OCNT wrap: 2^CNT_W-1 -> 0; no flag.
- Reset values: sync flops 0, req_q 0, ODATA 0, OVALID 0, OACK 0, OCNT 0, OERR 0, state IDLE.
- Reset mid-transfer abandons the word. The source side must be reset in the same event, because both toggle levels restart at 0.

## Timing
- Edge 1 is the first CLK edge that samples a changed IREQ.
- req_s changes at edge SYNC_STAGES. OVALID rises and ODATA is loaded at edge SYNC_STAGES+1. Default: 3 edges.
- Ready accepted at edge k: OVALID low and OACK toggled after edge k; OCNT updates at the same edge.
- Minimum round trip IREQ toggle -> OACK toggle: SYNC_STAGES+2 edges when IREADY is held 1.
- Back-to-back transfers are limited only by the source seeing OACK. There is no dead cycle in the receiver.
- OVALID must never drop without IREADY, except on RST.

## Structure
- Package cdc_pkg holds:
  - the state typedef (IDLE, VALID);
  - default W, SYNC_STAGES and CNT_W constants, shared with the trigger-chain stage.
- Sub-module sync_chain (parameter STAGES; ports CLK, RST, D, Q): plain flop chain, async reset to 0, no logic between stages.
- Top contains the edge detect, FSM, capture register, ack toggle, counter and error flag.

## Test plan
- Reset: assert RST mid-VALID with ODATA=4'hA.
  - Required: all outputs 0 immediately (asynchronously); state IDLE after release.
- Single transfer: IDATA=4'h5, toggle IREQ, IREADY=1.
  - Required: OVALID high with ODATA=5 at edge 3.
  - Required: OACK 0->1 and OCNT=1 at edge 4.
- Backpressure: IDATA=4'hC, IREADY=0 for 10 cycles, then 1.
  - Required: OVALID/ODATA=C held all 10 cycles.
  - Required: OACK toggles only on the accept edge.
- Source model: 20 transfers, random data, random IREADY, each new IREQ toggle issued only after OACK toggle.
  - Required: ODATA sequence equals IDATA sequence, OCNT=20, OERR=0.
- Violation: toggle IREQ twice while VALID.
  - Required: OERR=1 and stays 1, original ODATA delivered unchanged, OCNT increments once.
- Wrap: CNT_W=2, 5 transfers.
  - Required: OCNT sequence 1,2,3,0,1.
